// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the download packer.
package jtframe_dwnld_pkg;

  localparam int ADDRW = 25;

  // One queued download byte: address relative to the end of the header.
  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [7:0]       data;
  } dwnld_entry_t;

  // Active-low byte enables: bit0 = data[7:0], bit1 = data[15:8]
  localparam logic [1:0] MASK_NONE = 2'b11;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_BOTH = 2'b00;

  typedef enum logic { IDLE = 1'b0, ISSUE = 1'b1 } dwnld_state_t;

  // Even relative bytes go to the low lane unless the halves are swapped.
  function automatic logic [1:0] lane_mask(input logic odd, input logic swab);
    return (odd ^ swab) ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO for download bytes. A pop and a push in the same
// cycle are always accepted, even when full, because the pop frees the slot
// first. pop2_i (only with pop_i) retires the head and the entry behind it.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  dwnld_entry_t din_i,
  input  logic         pop_i,
  input  logic         pop2_i,
  output logic         empty_o,
  output logic         full_o,
  output logic         has2_o,
  output logic         drop_o,
  output dwnld_entry_t head_o,
  output dwnld_entry_t next_o
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  dwnld_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d, npop;
  logic           do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign has2_o  = (cnt_q >= CW'(2));
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + AW'(1)];

  // Pointer and occupancy update; a push into a full FIFO is dropped
  // unless a pop happens in the same cycle.
  always_comb begin
    npop    = pop2_i ? CW'(2) : (pop_i ? CW'(1) : '0);
    do_push = push_i & (~full_o | pop_i);
    drop_o  = push_i & full_o & ~pop_i;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + npop[AW-1:0];
    cnt_d   = cnt_q + CW'(do_push) - npop;
  end

  // Storage has no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_dwnld_packer.sv
// Packs the ioctl download byte stream into SDRAM programming writes.
// Header bytes are discarded, the rest are queued and written one per
// request, each held on prog_we until prog_rdy.
// Optional build macro JTFRAME_DWNLD_MERGE_EN: an even byte whose odd
// partner is already queued behind it is written together as one word.
module jtframe_dwnld_packer
  import jtframe_dwnld_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int HEADER = 0,
  parameter int FIFOAW = 3,
  parameter int SWAB   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);
`ifdef JTFRAME_DWNLD_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif
  localparam bit SWAP = (SWAB != 0);

  dwnld_state_t      state_q, state_d;
  logic [SDRAMW-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        mask_q, mask_d;
  logic              we_q, we_d;
  logic              ovf_q, ovf_d;
  logic              dl_q;

  dwnld_entry_t      push_e, head, nxt;
  logic              push_req, load, merge;
  logic              f_empty, f_full, f_has2, f_drop;

  // Only post-header bytes seen while downloading are queued.
  assign push_req    = ioctl_wr & downloading & (ioctl_addr >= 25'(HEADER));
  assign push_e.addr = ioctl_addr - 25'(HEADER);
  assign push_e.data = ioctl_data;

  jtframe_dwnld_fifo #(.AW(FIFOAW)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_req),
    .din_i  (push_e),
    .pop_i  (load),
    .pop2_i (merge),
    .empty_o(f_empty),
    .full_o (f_full),
    .has2_o (f_has2),
    .drop_o (f_drop),
    .head_o (head),
    .next_o (nxt)
  );

  // Next state: load a new write when idle or when the current one is
  // acknowledged, so back-to-back writes leave no gap on prog_we.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:  if (!f_empty) begin
               load    = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (prog_rdy) begin
               if (!f_empty) load = 1'b1;
               else          state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
    // Merge only with a partner that is already queued; never wait for it.
    merge = MERGE_EN & load & ~head.addr[0] & f_has2 &
            (nxt.addr == head.addr + 25'd1);
  end

  // Write request registers: loaded on pop, cleared after the last ack.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    we_d   = we_q;
    if (load) begin
      addr_d = SDRAMW'(head.addr >> 1);
      we_d   = 1'b1;
      if (merge) begin
        data_d = SWAP ? {head.data, nxt.data} : {nxt.data, head.data};
        mask_d = MASK_BOTH;
      end else begin
        data_d = {head.data, head.data};
        mask_d = lane_mask(head.addr[0], SWAP);
      end
    end else if (state_q == ISSUE && prog_rdy) begin
      we_d   = 1'b0;
      mask_d = MASK_NONE;
    end
  end

  // Sticky overflow, cleared at the start of each download; a drop in
  // the same cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    if (downloading && !dl_q) ovf_d = 1'b0;
    if (f_drop)               ovf_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= MASK_NONE;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      dl_q    <= downloading;
    end
  end

  assign prog_addr  = addr_q;
  assign prog_data  = data_q;
  assign prog_mask  = mask_q;
  assign prog_we    = we_q;
  assign overflow   = ovf_q;
  assign dwnld_busy = downloading | ~f_empty | we_q;

endmodule

// File: tb/tb_jtframe_dwnld_packer.sv
// Bench for jtframe_dwnld_packer (HEADER=64). A queue of accepted bytes
// predicts every acknowledged write; directed checks pin latency, header
// skip, overflow, merging and reset.
module tb_jtframe_dwnld_packer;
  localparam int H      = 64;
  localparam int SDRAMW = 22;
  localparam int FIFOAW = 3;
  localparam int SWAB   = 0;

  logic              clk = 1'b0, rst = 1'b1, downloading = 1'b0;
  logic              ioctl_wr = 1'b0, prog_rdy = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_data = '0;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic              prog_we, dwnld_busy, overflow;

  int n_chk = 0, n_fail = 0;

  typedef struct packed { logic [24:0] rel; logic [7:0] d; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  jtframe_dwnld_packer #(.SDRAMW(SDRAMW), .HEADER(H), .FIFOAW(FIFOAW), .SWAB(SWAB)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rdy(prog_rdy), .dwnld_busy(dwnld_busy),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every acknowledged write must match the oldest queued byte(s).
  logic              pw_q = 1'b0, prdy_q = 1'b0;
  logic [SDRAMW-1:0] pa_q;
  logic [15:0]       pd_q;
  logic [1:0]        pm_q;
  exp_t              e;
  logic [24:0]       sh;
  logic [15:0]       ed;
  logic [1:0]        em;
  bit                merged;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_we",   32'(prog_we),   32'd0);
      chk("rst_mask", 32'(prog_mask), 32'd3);
      chk("rst_addr", 32'(prog_addr), 32'd0);
      chk("rst_data", 32'(prog_data), 32'd0);
      chk("rst_ovf",  32'(overflow),  32'd0);
      pw_q = 1'b0;
    end else begin
      chk("busy", 32'(dwnld_busy), 32'(downloading || q.size() != 0));
      if (!prog_we) chk("idle_mask", 32'(prog_mask), 32'd3);
      if (pw_q && !prdy_q) begin
        chk("hold_we",   32'(prog_we),   32'd1);
        chk("hold_addr", 32'(prog_addr), 32'(pa_q));
        chk("hold_data", 32'(prog_data), 32'(pd_q));
        chk("hold_mask", 32'(prog_mask), 32'(pm_q));
      end
      if (prog_we && prog_rdy) begin
        if (q.size() == 0) begin
          chk("spurious_write", 32'(prog_we), 32'd0);
        end else begin
          e  = q[0];
          sh = e.rel >> 1;
          merged = 1'b0;
`ifdef JTFRAME_DWNLD_MERGE_EN
          if (prog_mask == 2'b00 && q.size() >= 2 && !e.rel[0] && q[1].rel == e.rel + 25'd1)
            merged = 1'b1;
`endif
          if (merged) begin
            ed = (SWAB != 0) ? {e.d, q[1].d} : {q[1].d, e.d};
            em = 2'b00;
          end else begin
            ed = {e.d, e.d};
            em = (e.rel[0] ^ (SWAB != 0)) ? 2'b01 : 2'b10;
          end
          chk("sb_addr", 32'(prog_addr), 32'(sh[SDRAMW-1:0]));
          chk("sb_data", 32'(prog_data), 32'(ed));
          chk("sb_mask", 32'(prog_mask), 32'(em));
          void'(q.pop_front());
          if (merged) void'(q.pop_front());
        end
      end
      pw_q = prog_we;
    end
    prdy_q = prog_rdy;
    pa_q = prog_addr;
    pd_q = prog_data;
    pm_q = prog_mask;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit acc);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (acc) q.push_back('{rel: a - 25'(H), d: d});
    cyc();
    ioctl_wr = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [SDRAMW-1:0] a,
                              input logic [15:0] d, input logic [1:0] m);
    int k = 0;
    while (!prog_we && k < 50) begin
      cyc();
      k++;
    end
    chk({name, "_we"},   32'(prog_we),   32'd1);
    chk({name, "_addr"}, 32'(prog_addr), 32'(a));
    chk({name, "_data"}, 32'(prog_data), 32'(d));
    chk({name, "_mask"}, 32'(prog_mask), 32'(m));
    prog_rdy = 1'b1;
    cyc();
    prog_rdy = 1'b0;
  endtask

  initial begin
    int run;
    // Reset state
    cyc(2);
    chk("rst_busy", 32'(dwnld_busy), 32'd0);
    rst = 1'b0;
    cyc();

    // Single byte: latency, lane, data duplication, hold and drop
    downloading = 1'b1;
    cyc();
    ioctl_addr = 25'(H); ioctl_data = 8'h5A; ioctl_wr = 1'b1;
    q.push_back('{rel: 25'd0, d: 8'h5A});
    cyc();
    ioctl_wr = 1'b0;
    chk("t1_we_n", 32'(prog_we), 32'd0);
    cyc();
    chk("t1_we_n1", 32'(prog_we),   32'd1);
    chk("t1_addr",  32'(prog_addr), 32'd0);
    chk("t1_data",  32'(prog_data), 32'h5A5A);
    chk("t1_mask",  32'(prog_mask), 32'd2);
    cyc(2);
    chk("t1_hold", 32'(prog_we), 32'd1);
    prog_rdy = 1'b1;
    cyc();
    prog_rdy = 1'b0;
    chk("t1_drop",      32'(prog_we),   32'd0);
    chk("t1_drop_mask", 32'(prog_mask), 32'd3);

    // Header bytes are discarded; first real odd byte goes high lane
    for (int i = 0; i < H; i++) send(25'(i), 8'(i) ^ 8'hA5, 1'b0);
    cyc();
    chk("hdr_no_we", 32'(prog_we), 32'd0);
    send(25'(H + 1), 8'hC3, 1'b1);
    expect_write("hdr", '0, 16'hC3C3, 2'b01);

    // Writes while not downloading are ignored
    downloading = 1'b0;
    cyc();
    send(25'(H + 80), 8'h77, 1'b0);
    cyc(3);
    chk("nodl_we",   32'(prog_we),    32'd0);
    chk("nodl_busy", 32'(dwnld_busy), 32'd0);
    downloading = 1'b1;
    cyc();

    // Overflow: 10 bytes with no ack; one sits in the write register,
    // eight fill the FIFO, the tenth is dropped
    for (int i = 0; i < 10; i++) send(25'(H + 16 + 3 * i), 8'h30 + 8'(i), i < 9);
    cyc();
    chk("ovf_flag", 32'(overflow),   32'd1);
    chk("ovf_busy", 32'(dwnld_busy), 32'd1);
    chk("ovf_we",   32'(prog_we),    32'd1);
    downloading = 1'b0;
    prog_rdy = 1'b1;
    run = 0;
    for (int k = 0; k < 40; k++) begin
      if (!prog_we) break;
      run++;
      cyc();
    end
    prog_rdy = 1'b0;
    chk("ovf_run",       run,                9);
    chk("ovf_busy_done", 32'(dwnld_busy),    32'd0);
    chk("ovf_sticky",    32'(overflow),      32'd1);
    downloading = 1'b1;
    cyc();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Pair arriving while a write is pending, then a lone odd byte
    send(25'(H + 40), 8'hEE, 1'b1);
    cyc(2);
    send(25'(H + 4), 8'h11, 1'b1);
    send(25'(H + 5), 8'h22, 1'b1);
    send(25'(H + 7), 8'h77, 1'b1);
    expect_write("m_first", 22'd20, 16'hEEEE, 2'b10);
`ifdef JTFRAME_DWNLD_MERGE_EN
    expect_write("m_pair", 22'd2, 16'h2211, 2'b00);
`else
    expect_write("m_lo", 22'd2, 16'h1111, 2'b10);
    expect_write("m_hi", 22'd2, 16'h2222, 2'b01);
`endif
    expect_write("m_lone", 22'd3, 16'h7777, 2'b01);

    // Reset while a write is pending with three more queued
    send(25'(H + 100), 8'hA0, 1'b1);
    send(25'(H + 103), 8'hA1, 1'b1);
    send(25'(H + 106), 8'hA2, 1'b1);
    send(25'(H + 109), 8'hA3, 1'b1);
    cyc();
    chk("prerst_we", 32'(prog_we), 32'd1);
    downloading = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    chk("mrst_we",   32'(prog_we),   32'd0);
    chk("mrst_mask", 32'(prog_mask), 32'd3);
    cyc(2);
    rst = 1'b0;
    cyc();
    chk("post_busy", 32'(dwnld_busy), 32'd0);
    chk("post_we",   32'(prog_we),    32'd0);
    prog_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("post_no_write", 32'(prog_we), 32'd0);
    end
    prog_rdy = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
